// File: rtl/muldiv_seq.sv
// Sequencer that launches the multiplier or divider and commits HI/LO on completion.
// Optional run watchdog enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic req_mult,
  input  logic req_div,
  input  logic mult_fim,
  input  logic div_fim,
  input  logic div_by_zero,
  output logic mult_start,
  output logic div_start,
  output logic hi_sel,
  output logic lo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    WRITE    = 3'd3,
    EXC      = 3'd4
  } state_t;

  state_t state;
  logic   op;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("muldiv_seq: TIMEOUT_CYCLES must lie in 2..255");
  end

  // The mux selects simply follow the latched operation, so they are registered.
  assign hi_sel = op;
  assign lo_sel = op;

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] runCount;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      op           <= 1'b0;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hi_write     <= 1'b0;
      lo_write     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      runCount     <= 8'd0;
      timeout      <= 1'b0;
`endif
    end else begin
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hi_write     <= 1'b0;
      lo_write     <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_mult) begin
            state      <= MULT_RUN;
            op         <= 1'b0;
            mult_start <= 1'b1;
            busy       <= 1'b1;
`ifdef MULDIV_TIMEOUT_EN
            runCount   <= 8'd0;
`endif
          end else if (req_div) begin
            state     <= DIV_RUN;
            op        <= 1'b1;
            div_start <= 1'b1;
            busy      <= 1'b1;
`ifdef MULDIV_TIMEOUT_EN
            runCount  <= 8'd0;
`endif
          end
        end
        // Flags seen while the start pulse is still out belong to a previous op.
        MULT_RUN: begin
          if (!mult_start && mult_fim) begin
            state    <= WRITE;
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            done     <= 1'b1;
          end
`ifdef MULDIV_TIMEOUT_EN
          else if (runCount == TimeoutLast) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            runCount <= runCount + 8'd1;
          end
`endif
        end
        DIV_RUN: begin
          if (!div_start && div_by_zero) begin
            state        <= EXC;
            div_zero_exc <= 1'b1;
          end else if (!div_start && div_fim) begin
            state    <= WRITE;
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            done     <= 1'b1;
          end
`ifdef MULDIV_TIMEOUT_EN
          else if (runCount == TimeoutLast) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            runCount <= runCount + 8'd1;
          end
`endif
        end
        WRITE, EXC: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised transaction bench for muldiv_seq; expected per-cycle outputs come
// from the operation timeline (start, run, flag, write/exception, idle).
module tb_muldiv_seq;

  logic clock = 1'b0;
  logic reset, req_mult, req_div, mult_fim, div_fim, div_by_zero;
  logic mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write;
  logic busy, done, div_zero_exc, timeout;
  logic [9:0] outs;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .req_mult(req_mult), .req_div(req_div),
    .mult_fim(mult_fim), .div_fim(div_fim), .div_by_zero(div_by_zero),
    .mult_start(mult_start), .div_start(div_start), .hi_sel(hi_sel), .lo_sel(lo_sel),
    .hi_write(hi_write), .lo_write(lo_write), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .timeout(timeout)
  );

  always #5 clock = ~clock;

  assign outs = {mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
                 busy, done, div_zero_exc, timeout};

  function automatic logic [9:0] ev(input bit ms, ds, op, wr, bsy, dn, exc, to);
    return {ms, ds, op, op, wr, wr, bsy, dn, exc, to};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (mst dst hs ls hw lw bsy dn exc to)", tag, obs, expv);
    end
  endtask

  // One complete operation: request seen at the edge ending the current IDLE
  // cycle, the completing flag sampled at the end of RUN cycle d.
  task automatic txn(input bit rm, input bit rd, input int d, input bit zero);
    bit isMult;
    bit opE;
    isMult = rm;
    opE    = rm ? 1'b0 : 1'b1;
    req_mult = rm; req_div = rd;
    mult_fim = 1'($urandom); div_fim = 1'($urandom); div_by_zero = 1'($urandom);
    step();
    chk("start", outs, ev(isMult, !isMult, opE, 0, 1, 0, 0, 0));
    for (int c = 1; c <= d; c++) begin
      req_mult = 1'($urandom); req_div = 1'($urandom);
      if (isMult) begin
        mult_fim    = (c == d) ? 1'b1 : ((c == 1) ? 1'($urandom) : 1'b0);
        div_fim     = 1'($urandom);
        div_by_zero = 1'($urandom);
      end else begin
        mult_fim    = 1'($urandom);
        div_fim     = (c == d) ? 1'b1 : ((c == 1) ? 1'($urandom) : 1'b0);
        div_by_zero = (c == d) ? zero : ((c == 1) ? 1'($urandom) : 1'b0);
      end
      step();
      if (c < d) chk($sformatf("run%0d", c + 1), outs, ev(0, 0, opE, 0, 1, 0, 0, 0));
    end
    req_mult = 1'($urandom); req_div = 1'($urandom);
    mult_fim = 1'($urandom); div_fim = 1'($urandom); div_by_zero = 1'($urandom);
    if (!isMult && zero) chk("exc", outs, ev(0, 0, opE, 0, 1, 0, 1, 0));
    else                 chk("write", outs, ev(0, 0, opE, 1, 1, 1, 0, 0));
    step();
    req_mult = 1'b0; req_div = 1'b0;
    chk("idle", outs, ev(0, 0, opE, 0, 0, 0, 0, 0));
    $display("txn mult=%0d div=%0d runCycles=%0d zero=%0d op=%0d checks=%0d errors=%0d",
             rm, rd, d, zero, opE, checks, errors);
  endtask

  initial begin
    bit rm, rd;
    reset = 1'b1; req_mult = 1'b0; req_div = 1'b0;
    mult_fim = 1'b0; div_fim = 1'b0; div_by_zero = 1'b0;
    step(); step();
    chk("reset", outs, 10'b0);
    reset = 1'b0;
    step();
    chk("idle0", outs, 10'b0);

    txn(1, 0, 5, 0);            // multiply, flag at edge 5 -> WRITE in cycle 6
    txn(0, 1, 4, 0);            // divide completes, then multiply back-to-back
    txn(1, 0, 2, 0);            // minimum latency
    txn(0, 1, 3, 1);            // zero divisor beats simultaneous div_fim
    txn(1, 1, 3, 0);            // multiply wins over divide
    txn(0, 1, 8, 0);            // flag on the last allowed run cycle
    for (int i = 0; i < 12; i++) begin
      rm = 1'($urandom);
      rd = rm ? 1'($urandom) : 1'b1;
      txn(rm, rd, int'($urandom_range(2, 8)), 1'($urandom));
    end

    // Reset in the second multiply run cycle, stale completion afterwards.
    txn(0, 1, 2, 0);
    req_mult = 1'b1;
    step();
    req_mult = 1'b0;
    chk("rst_start", outs, ev(1, 0, 0, 0, 1, 0, 0, 0));
    step();
    reset = 1'b1; mult_fim = 1'b1;
    step();
    chk("rst_mid", outs, 10'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_after%0d", i), outs, 10'b0);
    end
    mult_fim = 1'b0;
    $display("reset mid-run checks=%0d errors=%0d", checks, errors);

    // Multiply with no completion flag.
    req_mult = 1'b1;
    step();
    req_mult = 1'b0;
    chk("to_start", outs, ev(1, 0, 0, 0, 1, 0, 0, 0));
`ifdef MULDIV_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      step();
      chk($sformatf("to_run%0d", c), outs, ev(0, 0, 0, 0, 1, 0, 0, 0));
    end
    step();
    chk("to_pulse", outs, ev(0, 0, 0, 0, 0, 0, 0, 1));
    step();
    chk("to_idle", outs, 10'b0);
`else
    for (int c = 2; c <= 20; c++) begin
      step();
      chk($sformatf("hang_run%0d", c), outs, ev(0, 0, 0, 0, 1, 0, 0, 0));
    end
    mult_fim = 1'b1;
    step();
    mult_fim = 1'b0;
    chk("hang_write", outs, ev(0, 0, 0, 1, 1, 1, 0, 0));
    step();
    chk("hang_idle", outs, 10'b0);
`endif
    $display("no-flag run checks=%0d errors=%0d", checks, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum RUN-state cycles before abort (legal range 2..255; used only when MULDIV_TIMEOUT_EN is defined).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_mult  input  1  multiply request from main control, level-sampled in IDLE.
REQ-005 req_div  input  1  divide request from main control, level-sampled in IDLE.
REQ-006 mult_fim  input  1  multiplier completion flag.
REQ-007 div_fim  input  1  divider completion flag.
REQ-008 div_by_zero  input  1  divider divide-by-zero flag.
REQ-009 mult_start  output  1  one-cycle launch pulse to multiplier.
REQ-010 div_start  output  1  one-cycle launch pulse to divider.
REQ-011 hi_sel  output  1  HI mux select: 0 = multiplier, 1 = divider.
REQ-012 lo_sel  output  1  LO mux select: 0 = multiplier, 1 = divider.
REQ-013 hi_write  output  1  HI register write enable.
REQ-014 lo_write  output  1  LO register write enable.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 div_zero_exc  output  1  one-cycle pulse when a divide aborts on zero divisor.
REQ-018 timeout  output  1  one-cycle pulse when a run aborts on timeout.

Function
REQ-019 FSM states SHALL be IDLE, MULT_RUN, DIV_RUN, WRITE, EXC; state, op register and all outputs SHALL be registered.
REQ-020 IDLE, req_mult=1 at edge k: go to MULT_RUN and set op=0; mult_start=1 during cycle k+1 only.
REQ-021 IDLE, req_div=1 and req_mult=0 at edge k: go to DIV_RUN and set op=1; div_start=1 during cycle k+1 only.
REQ-022 Simultaneous req_mult and req_div in IDLE: multiply wins; the divide request is dropped, not queued.
REQ-023 Requests while busy=1 SHALL be ignored; no queuing.
REQ-024 Completion and zero flags SHALL be ignored in the cycle their start pulse is high, and at all times in IDLE.
REQ-025 MULT_RUN: mult_fim=1 sampled at edge m -> WRITE in cycle m+1.
REQ-026 DIV_RUN: div_by_zero=1 at edge m -> EXC in cycle m+1, with priority over a simultaneous div_fim; otherwise div_fim=1 -> WRITE.
REQ-027 WRITE, exactly one cycle: hi_write=lo_write=done=1 and hi_sel=lo_sel=op; then IDLE.
REQ-028 EXC, exactly one cycle: div_zero_exc=1, hi_write=lo_write=0 (HI/LO unchanged); then IDLE.
REQ-029 hi_sel/lo_sel SHALL hold op in every state; op changes only when a request is accepted.
REQ-030 Minimum request-to-done latency: 3 cycles (start cycle, flag cycle, WRITE cycle).
REQ-031 A request may be accepted in the cycle immediately after WRITE or EXC returns to IDLE.

Reset
REQ-032 reset=1 at a clock edge, in any state including mid-run: state=IDLE, op=0, timeout counter=0, all outputs 0.
REQ-033 Reset SHALL NOT cause an HI/LO write; completion flags from an interrupted run SHALL have no effect after reset.

Configuration
REQ-034 Macro MULDIV_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering MULT_RUN/DIV_RUN and increment each RUN cycle.
REQ-035 With MULDIV_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES with no flag seen: timeout=1 for one cycle, no HI/LO write, return to IDLE.
REQ-036 With MULDIV_TIMEOUT_EN, a completion or zero flag in the same cycle as the timeout SHALL win over the timeout.
REQ-037 Without MULDIV_TIMEOUT_EN: no counter, RUN states wait indefinitely, timeout port SHALL be present and tied to 0.

Verification
REQ-038 req_mult pulse at edge 0, mult_fim at edge 5 -> mult_start high in cycle 1, WRITE in cycle 6 with hi_write=lo_write=done=1 and hi_sel=0; busy high in cycles 1-6.
REQ-039 req_div, div_fim at 4th RUN cycle -> div_start one cycle, done with hi_sel=lo_sel=1; then req_mult accepted in the next IDLE cycle.
REQ-040 req_div, div_by_zero=1 and div_fim=1 same edge -> EXC: div_zero_exc=1, hi_write=0, done=0, then IDLE.
REQ-041 req_mult=req_div=1 same edge -> only mult_start pulses, op=0; req_div held during the run has no effect.
REQ-042 reset at 2nd MULT_RUN cycle, then mult_fim=1 -> all outputs 0, state IDLE, no hi_write.
REQ-043 MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mult_fim -> timeout pulse after 8 RUN cycles, no write, then IDLE; same stimulus without the macro -> busy stays high, timeout=0.
